// File: rtl/psum_accumulator_if.sv
// psum_accumulator_if
//   Bundles the two streams around the partial-sum accumulator.
//   psum_in/psum_valid : psum beat from the systolic array (no backpressure)
//   out_data/out_valid/out_ready : accumulated tile drained to the output writer
// Modports:
//   master : the environment side (array + output writer)
//   slave  : the accumulator itself
interface psum_accumulator_if #(
  parameter int C_WIDTH = 32,
  parameter int LANES   = 4
);
  logic [C_WIDTH*LANES-1:0] psum_in;
  logic                     psum_valid;
  logic [C_WIDTH*LANES-1:0] out_data;
  logic                     out_valid;
  logic                     out_ready;

  modport master (
    output psum_in, psum_valid, out_ready,
    input  out_data, out_valid
  );

  modport slave (
    input  psum_in, psum_valid, out_ready,
    output out_data, out_valid
  );
endinterface

// File: rtl/psum_accumulator.sv
// psum_accumulator
//   Accumulates psum beats from the systolic array across num_passes channel
//   tiles for a tile of num_pixels output pixels held in a register-file
//   buffer, then drains the finished tile over a valid/ready stream.
// Ports:
//   clk        : clock, all state on rising edge
//   rst        : asynchronous active-low reset
//   start      : begin a tile (sampled in IDLE only)
//   num_pixels : beats per pass, legal 1..DEPTH
//   num_passes : passes to accumulate, legal 1..2^PASS_W-1
//   ps         : psum input stream and drain output stream (interface, slave)
//   busy       : high while accumulating or draining
//   done       : one-cycle pulse after the last drain beat is accepted
//   drop_err   : sticky, a beat arrived outside accumulation
//   cfg_err    : sticky, start seen with illegal configuration
// Build option:
//   PSUM_SAT_EN : when defined, lane additions saturate instead of wrapping.
//
// state  | meaning
// IDLE   | waiting for start, config checked here
// ACCUM  | writing/accumulating incoming beats into the buffer
// DRAIN  | streaming buffer entries out to the writer
module psum_accumulator #(
  parameter int C_WIDTH = 32,
  parameter int LANES   = 4,
  parameter int DEPTH   = 64,
  parameter int PASS_W  = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(DEPTH):0]     num_pixels,
  input  logic [PASS_W-1:0]          num_passes,
  psum_accumulator_if.slave          ps,
  output logic                       busy,
  output logic                       done,
  output logic                       drop_err,
  output logic                       cfg_err
);
  localparam int PIX_W  = $clog2(DEPTH) + 1;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam int BEAT_W = C_WIDTH * LANES;

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [PIX_W-1:0]    pix_idx_q, pix_idx_d;
  logic [PASS_W-1:0]   pass_idx_q, pass_idx_d;
  logic [PIX_W-1:0]    npix_q, npix_d;
  logic [PASS_W-1:0]   npass_q, npass_d;
  logic [BEAT_W-1:0]   out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                done_q, done_d;
  logic                drop_err_q, drop_err_d;
  logic                cfg_err_q, cfg_err_d;

  logic [BEAT_W-1:0]   buf_mem [DEPTH];
  logic                mem_we;
  logic [BEAT_W-1:0]   mem_wdata;
  logic [BEAT_W-1:0]   cur_data, nxt_data, acc_beat;
  logic [PIX_W-1:0]    pix_nxt;
  logic                pix_last, pass_last, cfg_bad;

  function automatic logic [C_WIDTH-1:0] lane_add(input logic [C_WIDTH-1:0] a,
                                                  input logic [C_WIDTH-1:0] b);
`ifdef PSUM_SAT_EN
    logic [C_WIDTH:0] s;
    s = {a[C_WIDTH-1], a} + {b[C_WIDTH-1], b};
    // The two top bits differ exactly when the signed sum overflowed.
    if (s[C_WIDTH] != s[C_WIDTH-1])
      lane_add = s[C_WIDTH] ? {1'b1, {(C_WIDTH-1){1'b0}}} : {1'b0, {(C_WIDTH-1){1'b1}}};
    else
      lane_add = s[C_WIDTH-1:0];
`else
    lane_add = a + b;
`endif
  endfunction

  // Combinational read; the write of the same entry lands at the clock edge,
  // so back-to-back beats to one entry always see the previous sum.
  assign pix_nxt   = pix_idx_q + PIX_W'(1);
  assign cur_data  = buf_mem[pix_idx_q[IDX_W-1:0]];
  assign nxt_data  = buf_mem[pix_nxt[IDX_W-1:0]];
  assign pix_last  = (pix_idx_q == npix_q - PIX_W'(1));
  assign pass_last = (pass_idx_q == npass_q - PASS_W'(1));
  assign cfg_bad   = (num_pixels == '0) || (num_pixels > PIX_W'(DEPTH)) || (num_passes == '0);

  always_comb begin
    acc_beat = '0;
    for (int v = 0; v < LANES; v++)
      acc_beat[v*C_WIDTH +: C_WIDTH] = lane_add(cur_data[v*C_WIDTH +: C_WIDTH],
                                                ps.psum_in[v*C_WIDTH +: C_WIDTH]);
  end

  always_comb begin
    state_d     = state_q;
    pix_idx_d   = pix_idx_q;
    pass_idx_d  = pass_idx_q;
    npix_d      = npix_q;
    npass_d     = npass_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    drop_err_d  = drop_err_q;
    cfg_err_d   = cfg_err_q;
    mem_we      = 1'b0;
    mem_wdata   = '0;

    if (ps.psum_valid && (state_q != S_ACCUM))
      drop_err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            npix_d     = num_pixels;
            npass_d    = num_passes;
            pix_idx_d  = '0;
            pass_idx_d = '0;
            state_d    = S_ACCUM;
          end
        end
      end
      S_ACCUM: begin
        if (ps.psum_valid) begin
          mem_we    = 1'b1;
          mem_wdata = (pass_idx_q == '0) ? ps.psum_in : acc_beat;
          if (pix_last) begin
            pix_idx_d = '0;
            if (pass_last) state_d = S_DRAIN;
            else           pass_idx_d = pass_idx_q + PASS_W'(1);
          end else begin
            pix_idx_d = pix_nxt;
          end
        end
      end
      S_DRAIN: begin
        // pix_idx tracks the entry currently presented on out_data.
        if (!out_valid_q) begin
          out_data_d  = cur_data;
          out_valid_d = 1'b1;
        end else if (ps.out_ready) begin
          if (pix_last) begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            pix_idx_d   = '0;
            state_d     = S_IDLE;
          end else begin
            out_data_d = nxt_data;
            pix_idx_d  = pix_nxt;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pix_idx_q   <= '0;
      pass_idx_q  <= '0;
      npix_q      <= '0;
      npass_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      drop_err_q  <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_idx_q   <= pix_idx_d;
      pass_idx_q  <= pass_idx_d;
      npix_q      <= npix_d;
      npass_q     <= npass_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      drop_err_q  <= drop_err_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  // Buffer is intentionally not reset; pass 0 always overwrites.
  always_ff @(posedge clk) begin
    if (mem_we) buf_mem[pix_idx_q[IDX_W-1:0]] <= mem_wdata;
  end

  assign ps.out_data  = out_data_q;
  assign ps.out_valid = out_valid_q;
  assign busy         = (state_q != S_IDLE);
  assign done         = done_q;
  assign drop_err     = drop_err_q;
  assign cfg_err      = cfg_err_q;
endmodule
